// File: rtl/logic_pkg.sv
// Shared definitions for the logic unit and its result FIFO.
// Op codes, default widths and the packed FIFO entry layout.
package logic_pkg;

    localparam logic [1:0] OP_AND = 2'd0;
    localparam logic [1:0] OP_OR  = 2'd1;
    localparam logic [1:0] OP_XOR = 2'd2;
    localparam logic [1:0] OP_NOT = 2'd3;

    localparam int DATA_W_DEF = 8;
    localparam int OP_W_DEF   = 2;

    // Entry as stored in the FIFO; flags are captured at write time.
    typedef struct packed {
        logic                  zero;
        logic                  parity;
        logic [OP_W_DEF-1:0]   sw;
        logic [DATA_W_DEF-1:0] f;
    } entry_t;

endpackage

// File: rtl/logic_result_flags.sv
// Zero and parity flags for one result word.
// Purely combinational; used on the FIFO write side.
module logic_result_flags
    import logic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] f_i,
    output logic              zero_o,
    output logic              parity_o
);

    // Odd number of ones gives parity 1.
    always_comb begin
        zero_o   = (f_i == '0);
        parity_o = ^f_i;
    end

endmodule

// File: rtl/logic_result_fifo.sv
// First-word-fall-through result FIFO behind the logic unit.
// Entries carry {zero, parity, sw, f}; occupancy decides full/empty.
module logic_result_fifo
    import logic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_f,
    input  logic [OP_W-1:0]            in_sw,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_f,
    output logic [OP_W-1:0]            out_sw,
    output logic                       out_zero,
    output logic                       out_parity,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       drop_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = DATA_W + OP_W + 2;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          drop_q, drop_d;
    logic          push, pop;
    logic          wr_zero, wr_parity;
    logic [EW-1:0] head;

    logic_result_flags #(.DATA_W(DATA_W)) u_flags (
        .f_i      (in_f),
        .zero_o   (wr_zero),
        .parity_o (wr_parity)
    );

    // Handshake status comes only from registered occupancy.
    always_comb begin
        in_ready  = (count_q != FULL);
        out_valid = (count_q != '0);
        push      = in_valid & in_ready & ~clear;
        pop       = out_valid & out_ready & ~clear;
    end

    // Next-state for pointers, occupancy and the sticky drop flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            drop_d   = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop) count_d = count_q + CW'(1);
            if (pop && !push) count_d = count_q - CW'(1);
            if (in_valid && !in_ready) drop_d = 1'b1;
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Storage write; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {wr_zero, wr_parity, in_sw, in_f};
    end

    // Head entry falls through to the outputs.
    always_comb begin
        head       = mem_q[rd_ptr_q];
        out_f      = head[DATA_W-1:0];
        out_sw     = head[DATA_W +: OP_W];
        out_parity = head[EW-2];
        out_zero   = head[EW-1];
        count      = count_q;
        drop_err   = drop_q;
    end

endmodule

// File: tb/tb_logic_result_fifo.sv
// Directed, table-driven bench for logic_result_fifo.
// Vectors hold inputs and hand-computed expected outputs.
module tb_logic_result_fifo;
    import logic_pkg::*;

    logic       clk = 1'b0;
    logic       rst, clear, in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_f, out_f;
    logic [1:0] in_sw, out_sw;
    logic       out_zero, out_parity, drop_err;
    logic [2:0] count;

    int errors = 0;
    int checks = 0;

    logic_result_fifo dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_f(in_f), .in_sw(in_sw),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_f(out_f), .out_sw(out_sw),
        .out_zero(out_zero), .out_parity(out_parity),
        .count(count), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [7:0] f;
        logic [1:0] sw;
        logic       ordy;
        logic       clr;
        logic       ev;
        logic [7:0] ef;
        logic [1:0] esw;
        logic       ez;
        logic       ep;
        logic [2:0] ec;
        logic       eir;
        logic       ed;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        logic iv, logic [7:0] f, logic [1:0] sw, logic ordy, logic clr,
        logic ev, logic [7:0] ef, logic [1:0] esw, logic ez, logic ep,
        logic [2:0] ec, logic eir, logic ed);
        vec_t v;
        v.iv = iv; v.f = f; v.sw = sw; v.ordy = ordy; v.clr = clr;
        v.ev = ev; v.ef = ef; v.esw = esw; v.ez = ez; v.ep = ep;
        v.ec = ec; v.eir = eir; v.ed = ed;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d got=%0h exp=%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [7:0] f,
                         input logic [1:0] sw, input logic ordy,
                         input logic clr);
        in_valid = iv; in_f = f; in_sw = sw;
        out_ready = ordy; clear = clr;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 8'h00, 2'd0, 0, 0);

        // Single word, two-word stall then drain.
        tbl.push_back(mk(1,8'h0A,OP_AND,0,0, 1,8'h0A,OP_AND,0,0,3'd1,1,0));
        tbl.push_back(mk(0,8'h00,0,1,0,      0,8'h00,0,0,0,3'd0,1,0));
        tbl.push_back(mk(1,8'h00,OP_XOR,0,0, 1,8'h00,OP_XOR,1,0,3'd1,1,0));
        tbl.push_back(mk(1,8'h07,OP_OR,0,0,  1,8'h00,OP_XOR,1,0,3'd2,1,0));
        tbl.push_back(mk(0,8'h00,0,0,0,      1,8'h00,OP_XOR,1,0,3'd2,1,0));
        tbl.push_back(mk(0,8'h00,0,1,0,      1,8'h07,OP_OR,0,1,3'd1,1,0));
        tbl.push_back(mk(0,8'h00,0,1,0,      0,8'h00,0,0,0,3'd0,1,0));
        // Fill to full, refused push, drain in order.
        tbl.push_back(mk(1,8'h01,OP_AND,0,0, 1,8'h01,OP_AND,0,1,3'd1,1,0));
        tbl.push_back(mk(1,8'h02,OP_AND,0,0, 1,8'h01,OP_AND,0,1,3'd2,1,0));
        tbl.push_back(mk(1,8'h03,OP_AND,0,0, 1,8'h01,OP_AND,0,1,3'd3,1,0));
        tbl.push_back(mk(1,8'hF0,OP_OR,0,0,  1,8'h01,OP_AND,0,1,3'd4,0,0));
        tbl.push_back(mk(1,8'h55,OP_XOR,1,0, 1,8'h02,OP_AND,0,1,3'd3,1,1));
        tbl.push_back(mk(0,8'h00,0,1,0,      1,8'h03,OP_AND,0,0,3'd2,1,1));
        tbl.push_back(mk(0,8'h00,0,1,0,      1,8'hF0,OP_OR,0,0,3'd1,1,1));
        tbl.push_back(mk(0,8'h00,0,1,0,      0,8'h00,0,0,0,3'd0,1,1));
        // Three words with drop_err set, then clear with a push.
        tbl.push_back(mk(1,8'hAA,OP_AND,0,0, 1,8'hAA,OP_AND,0,0,3'd1,1,1));
        tbl.push_back(mk(1,8'hBB,OP_OR,0,0,  1,8'hAA,OP_AND,0,0,3'd2,1,1));
        tbl.push_back(mk(1,8'hCC,OP_XOR,0,0, 1,8'hAA,OP_AND,0,0,3'd3,1,1));
        tbl.push_back(mk(1,8'hDD,OP_NOT,1,1, 0,8'h00,0,0,0,3'd0,1,0));
        tbl.push_back(mk(0,8'h00,0,0,0,      0,8'h00,0,0,0,3'd0,1,0));
        // Streaming 00..09 with pointer wrap.
        tbl.push_back(mk(1,8'h00,0,1,0, 1,8'h00,0,1,0,3'd1,1,0));
        tbl.push_back(mk(1,8'h01,1,1,0, 1,8'h01,1,0,1,3'd1,1,0));
        tbl.push_back(mk(1,8'h02,2,1,0, 1,8'h02,2,0,1,3'd1,1,0));
        tbl.push_back(mk(1,8'h03,3,1,0, 1,8'h03,3,0,0,3'd1,1,0));
        tbl.push_back(mk(1,8'h04,0,1,0, 1,8'h04,0,0,1,3'd1,1,0));
        tbl.push_back(mk(1,8'h05,1,1,0, 1,8'h05,1,0,0,3'd1,1,0));
        tbl.push_back(mk(1,8'h06,2,1,0, 1,8'h06,2,0,0,3'd1,1,0));
        tbl.push_back(mk(1,8'h07,3,1,0, 1,8'h07,3,0,1,3'd1,1,0));
        tbl.push_back(mk(1,8'h08,0,1,0, 1,8'h08,0,0,1,3'd1,1,0));
        tbl.push_back(mk(1,8'h09,1,1,0, 1,8'h09,1,0,0,3'd1,1,0));
        tbl.push_back(mk(0,8'h00,0,1,0, 0,8'h00,0,0,0,3'd0,1,0));

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valid", -1, 32'(out_valid), 32'd0);
        chk("rst_ready", -1, 32'(in_ready), 32'd1);
        chk("rst_count", -1, 32'(count), 32'd0);
        chk("rst_drop", -1, 32'(drop_err), 32'd0);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].iv, tbl[i].f, tbl[i].sw, tbl[i].ordy, tbl[i].clr);
            @(posedge clk);
            #1;
            chk("valid", i, 32'(out_valid), 32'(tbl[i].ev));
            chk("count", i, 32'(count), 32'(tbl[i].ec));
            chk("in_ready", i, 32'(in_ready), 32'(tbl[i].eir));
            chk("drop_err", i, 32'(drop_err), 32'(tbl[i].ed));
            if (tbl[i].ev) begin
                chk("out_f", i, 32'(out_f), 32'(tbl[i].ef));
                chk("out_sw", i, 32'(out_sw), 32'(tbl[i].esw));
                chk("out_zero", i, 32'(out_zero), 32'(tbl[i].ez));
                chk("out_parity", i, 32'(out_parity), 32'(tbl[i].ep));
            end
        end

        // Async reset with two words buffered.
        @(negedge clk);
        drive(1, 8'h11, OP_AND, 0, 0);
        @(negedge clk);
        drive(1, 8'h22, OP_OR, 0, 0);
        @(negedge clk);
        drive(0, 8'h00, 0, 0, 0);
        chk("pre_rst_count", 100, 32'(count), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("async_valid", 100, 32'(out_valid), 32'd0);
        chk("async_count", 100, 32'(count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 8'hFF, OP_NOT, 0, 0);
        @(posedge clk);
        #1;
        chk("post_valid", 101, 32'(out_valid), 32'd1);
        chk("post_count", 101, 32'(count), 32'd1);
        chk("post_f", 101, 32'(out_f), 32'hFF);
        chk("post_sw", 101, 32'(out_sw), 32'd3);
        chk("post_parity", 101, 32'(out_parity), 32'd0);
        chk("post_zero", 101, 32'(out_zero), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
